// File: rtl/ysyx_23060077_ex_div_ctrl.sv
// EX-stage divide sequencer: resolves RISC-V divide special cases and cache hits locally,
// otherwise drives the iterative divider with latched operands and absorbs flushes.
module ysyx_23060077_ex_div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_rs1,
  input  logic [DATA_WIDTH-1:0] req_rs2,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic                  div_valid,
  input  logic                  div_ready,
  output logic                  div_signed,
  output logic [DATA_WIDTH-1:0] dividend,
  output logic [DATA_WIDTH-1:0] divisor,
  input  logic                  out_valid,
  input  logic [DATA_WIDTH-1:0] quotient,
  input  logic [DATA_WIDTH-1:0] remainder
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t                  r_state, w_next;
  logic [1:0]              r_op;
  logic [DATA_WIDTH-1:0]   r_rs1, r_rs2, r_resp_data;
  logic                    r_cache_v, r_cache_sgn;
  logic [DATA_WIDTH-1:0]   r_cache_rs1, r_cache_rs2, r_cache_q, r_cache_r;

  logic                    w_sgn, w_want_rem, w_div_zero, w_overflow, w_hit, w_fast, w_accept;
  logic [DATA_WIDTH-1:0]   w_fast_data;

  assign w_sgn      = ~req_op[0];
  assign w_want_rem = req_op[1];
  assign w_div_zero = (req_rs2 == '0);
  assign w_overflow = w_sgn && (req_rs1 == MIN_NEG) && (req_rs2 == '1);
  assign w_hit      = r_cache_v && (req_rs1 == r_cache_rs1) && (req_rs2 == r_cache_rs2)
                      && (w_sgn == r_cache_sgn);
  assign w_fast     = w_div_zero || w_overflow || w_hit;
  assign w_accept   = (r_state == IDLE) && req_valid && !flush;

  // Priority: divide-by-zero, then signed overflow, then cached pair.
  always_comb begin
    w_fast_data = '0;
    if (w_div_zero)      w_fast_data = w_want_rem ? req_rs1 : '1;
    else if (w_overflow) w_fast_data = w_want_rem ? '0 : MIN_NEG;
    else                 w_fast_data = w_want_rem ? r_cache_r : r_cache_q;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_fast ? RESP : ISSUE;
      ISSUE:   if (flush) w_next = IDLE;
               else if (div_ready) w_next = WAIT;
      WAIT:    if (out_valid) w_next = flush ? IDLE : RESP;
               else if (flush) w_next = DRAIN;
      RESP:    w_next = IDLE;
      DRAIN:   if (out_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign div_valid  = (r_state == ISSUE) && div_ready && !flush;
  assign resp_valid = (r_state == RESP) && !flush;
  assign resp_data  = r_resp_data;
  assign div_signed = ~r_op[0];
  assign dividend   = r_rs1;
  assign divisor    = r_rs2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_resp_data <= '0;
      r_cache_v   <= 1'b0;
      r_cache_sgn <= 1'b0;
      r_cache_rs1 <= '0;
      r_cache_rs2 <= '0;
      r_cache_q   <= '0;
      r_cache_r   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= req_op;
        r_rs1 <= req_rs1;
        r_rs2 <= req_rs2;
        if (w_fast) r_resp_data <= w_fast_data;
      end
      // A completion seen in WAIT always refills the cache, even when flushed that cycle.
      if ((r_state == WAIT) && out_valid) begin
        r_resp_data <= r_op[1] ? remainder : quotient;
        r_cache_v   <= 1'b1;
        r_cache_sgn <= ~r_op[0];
        r_cache_rs1 <= r_rs1;
        r_cache_rs2 <= r_rs2;
        r_cache_q   <= quotient;
        r_cache_r   <= remainder;
      end
    end
  end

endmodule
